// File: rtl/dct2d_row_col_seq_if.sv
// Row-in / column-out stream bundle for dct2d_row_col_seq.
//
// Handshake rule (both directions): a transfer happens on the rising clock
// edge where valid && ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may change freely.
//
// Signals:
//   in_valid / in_ready / in_data[71:0]  : input rows, lane k = bits [9k+8:9k]
//   out_valid / out_ready                : output column handshake
//   out_data[143:0]                      : lane k = bits [18k+17:18k] = Y[k][out_col]
//   out_col[2:0]                         : horizontal frequency of out_data
//   out_last                             : marks column 7
// Modports: master = upstream fetcher + downstream quantiser side, slave = DCT block.
interface dct2d_row_col_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [71:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_data;
    logic [2:0]   out_col;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_col, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_col, out_last
    );
endinterface

// File: rtl/dct2d_row_col_seq.sv
// 8x8 2D DCT by row-column decomposition over one shared 8-point 1D DCT.
//
// ROW state: accepts 8 rows, transforms each, rounds by SHIFT1 to 9 bits and
// stores the result into a transpose buffer (row r, lane k -> tbuf[r][k]).
// COL state: feeds buffer column col_cnt back through the same datapath and
// loads the 18-bit result into a registered valid/ready output.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   bus (slave)   : in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//                   out_col, out_last
//   busy          : block in progress (state==COL or row_cnt!=0)
//   dbg_state     : 0 = ROW, 1 = COL
//   dbg_row_cnt   : number of rows accepted for the current block
module dct2d_row_col_seq #(
    parameter int SHIFT1 = 9
) (
    input  logic               clk,
    input  logic               rst,
    dct2d_row_col_seq_if.slave bus,
    output logic               busy,
    output logic               dbg_state,
    output logic [2:0]         dbg_row_cnt
);
    localparam int IW = 9;
    localparam int OW = 18;

    typedef enum logic {ROW = 1'b0, COL = 1'b1} state_t;

    state_t              state;
    logic [2:0]          row_cnt;
    logic [2:0]          col_cnt;
    logic                out_valid_r;
    logic [8*OW-1:0]     out_data_r;
    logic [2:0]          out_col_r;
    logic                out_last_r;

    logic signed [IW-1:0] tbuf [8][8];

    // Datapath runs entirely at OW bits: every final coefficient fits in OW
    // for 9-bit inputs, so any wrap in intermediate sums cancels out.
    logic signed [OW-1:0] dx [8];
    logic signed [OW-1:0] e  [4];
    logic signed [OW-1:0] o  [4];
    logic signed [OW-1:0] ee [2];
    logic signed [OW-1:0] eo [2];
    logic signed [OW-1:0] dy [8];
    logic [IW-1:0]        rq [8];
    logic [8*OW-1:0]      dy_flat;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            if (state == ROW) dx[j] = OW'(signed'(bus.in_data[IW*j +: IW]));
            else              dx[j] = OW'(tbuf[j][col_cnt]);
        end
        for (int n = 0; n < 4; n++) begin
            e[n] = dx[n] + dx[7-n];
            o[n] = dx[n] - dx[7-n];
        end
        ee[0] = e[0] + e[3];
        ee[1] = e[1] + e[2];
        eo[0] = e[0] - e[3];
        eo[1] = e[1] - e[2];
        dy[0] = 18'sd64 * (ee[0] + ee[1]);
        dy[4] = 18'sd64 * (ee[0] - ee[1]);
        dy[2] = 18'sd83 * eo[0] + 18'sd36 * eo[1];
        dy[6] = 18'sd36 * eo[0] - 18'sd83 * eo[1];
        dy[1] = 18'sd89 * o[0] + 18'sd75 * o[1] + 18'sd50 * o[2] + 18'sd18 * o[3];
        dy[3] = 18'sd75 * o[0] - 18'sd18 * o[1] - 18'sd89 * o[2] - 18'sd50 * o[3];
        dy[5] = 18'sd50 * o[0] - 18'sd89 * o[1] + 18'sd18 * o[2] + 18'sd75 * o[3];
        dy[7] = 18'sd18 * o[0] - 18'sd50 * o[1] + 18'sd75 * o[2] - 18'sd89 * o[3];
        dy_flat = '0;
        for (int k = 0; k < 8; k++) begin
            dy_flat[OW*k +: OW] = dy[k];
            // (y + 2^(S-1)) >>> S == floor(y / 2^S) + bit (S-1) of y
            rq[k] = dy[k][SHIFT1 +: IW] + IW'(dy[k][SHIFT1-1]);
        end
    end

    // Transpose buffer: no reset, contents are don't-care until rows land.
    always_ff @(posedge clk) begin
        if (state == ROW && bus.in_valid) begin
            for (int k = 0; k < 8; k++) tbuf[row_cnt][k] <= rq[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ROW;
            row_cnt     <= 3'd0;
            col_cnt     <= 3'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_col_r   <= 3'd0;
            out_last_r  <= 1'b0;
        end else begin
            case (state)
                ROW: begin
                    // Column 7 of the previous block may still be draining.
                    if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
                    if (bus.in_valid) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state   <= COL;
                            col_cnt <= 3'd0;
                        end
                    end
                end
                COL: begin
                    if (!out_valid_r || bus.out_ready) begin
                        out_data_r  <= dy_flat;
                        out_col_r   <= col_cnt;
                        out_last_r  <= (col_cnt == 3'd7);
                        out_valid_r <= 1'b1;
                        col_cnt     <= col_cnt + 3'd1;
                        if (col_cnt == 3'd7) state <= ROW;
                    end
                end
                default: state <= ROW;
            endcase
        end
    end

    assign bus.in_ready  = (state == ROW);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_col   = out_col_r;
    assign bus.out_last  = out_last_r;
    assign busy          = (state == COL) || (row_cnt != 3'd0);
    assign dbg_state     = (state == COL);
    assign dbg_row_cnt   = row_cnt;
endmodule
